march_sequencer: RTL and testbench
==================================

Name: march_sequencer

Overview:
- Controller that sequences the memory BIST datapath through a stored march program of up to DEPTH elements.
- For each element it presents the element's scan word, pulses the test-start strobe, waits for element completion, and monitors compare results.
- Reports pass/fail, the first-fail element index and address, and a watchdog timeout.
- Sits between the test host (program/start interface) and the BIST datapath's scan_in/ts_in/passfail_out/tas_out.

Parameters:
SW, 16, scan word width (matches BIST scan_in)
AW, 8, address width (matches BIST tas_out)
DEPTH, 8, march program entries (power of 2)
IW, 3, index width, log2(DEPTH)
TMO, 1024, watchdog limit in cycles per element

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
prog_we  in  1  program entry write strobe
prog_addr  in  IW  program entry index
prog_wdata  in  SW  program entry scan word
prog_len  in  IW+1  number of elements to run, 0..DEPTH; sampled at start
start  in  1  run request, single-cycle pulse
abort  in  1  terminate run
elem_done_in  in  1  BIST element-complete pulse
cmp_valid_in  in  1  passfail_in qualified (read cycle)
passfail_in  in  1  BIST compare result, 1 = match
tas_in  in  AW  BIST current address
scan_out  out  SW  scan word to BIST, registered
ts_out  out  1  test-start strobe to BIST
busy  out  1  run in progress
done  out  1  run finished, single-cycle pulse
fail  out  1  sticky fail flag
timeout  out  1  sticky watchdog flag
fail_idx  out  IW  element index of first failure
fail_addr  out  AW  address of first failure

Behaviour:
- Reset: all outputs 0; FSM = IDLE; program store cleared to 0.
- FSM states: IDLE, LOAD, STRT, RUN, NEXT, FIN.
- IDLE:
  - prog_we writes prog[prog_addr] <= prog_wdata.
  - prog_we is ignored in every other state.
  - start: latch prog_len; clear fail, timeout, fail_idx, fail_addr; idx <= 0; busy <= 1; go to LOAD.
  - If the latched length is 0, go to FIN instead of LOAD.
- LOAD: scan_out <= prog[idx]; go to STRT. scan_out holds this value until the next LOAD.
- STRT: ts_out = 1 for exactly this one cycle; clear watchdog; go to RUN.
- RUN:
  - Each cycle with cmp_valid_in & !passfail_in: set fail.
  - On the first such event only, also capture fail_idx <= idx and fail_addr <= tas_in.
  - elem_done_in: go to NEXT.
  - Watchdog reaching TMO-1 without elem_done_in: set timeout; go to FIN.
  - A compare failure and elem_done_in in the same cycle: failure is recorded, then go to NEXT.
- NEXT: if idx == len-1, go to FIN; otherwise idx <= idx+1 (wraps within IW bits only at DEPTH) and go to LOAD.
- FIN: done = 1 for one cycle; busy <= 0; go to IDLE. fail, timeout, fail_idx and fail_addr hold until the next start.
- start while busy is ignored.
- abort (any non-IDLE state): go to IDLE next cycle; busy <= 0; ts_out <= 0; done is not pulsed; flags keep their current values. abort has priority over all other events.
- elem_done_in outside RUN is ignored.
- Per-element overhead is 3 cycles (LOAD, STRT, NEXT). From start pulse to first ts_out is 2 cycles.

Optional Feature:
- Macro MARCH_SEQ_STOP_ON_FAIL_EN.
- Defined: the first recorded failure in RUN moves the FSM to FIN on the next cycle; remaining elements are skipped; done pulses normally.
- Undefined: the run always completes all elements; fail stays sticky.

Decomposition:
- Shared defines/package march_seq_defs holds:
  - state encodings (3-bit, IDLE = 0);
  - scan-word field positions reused from the BIST scan layout;
  - default TMO.
- One sub-module, march_watchdog: cycle counter with clear/enable and an expire output at TMO-1.

Test Plan:
- Program 3 entries (0x1111, 0x2222, 0x3333), len=3, start, elem_done_in 10 cycles after each ts_out -> scan_out steps 0x1111/0x2222/0x3333; 3 ts_out pulses; done pulses; fail=0, timeout=0.
- len=3, passfail_in=0 with cmp_valid_in during element 1 at tas_in=0x5A, and again in element 2 -> fail=1, fail_idx=1, fail_addr=0x5A (first failure only). With MARCH_SEQ_STOP_ON_FAIL_EN defined: no ts_out for element 2.
- len=2, never assert elem_done_in -> timeout=1 and done pulse TMO+1 cycles after ts_out; element 1 never loaded.
- abort 4 cycles into RUN of element 0 -> busy=0 next cycle, no done; then a new start runs correctly with flags cleared.
- len=0 start -> done 2 cycles after start, no ts_out. prog_we during busy -> entry unchanged when read back on the next run.
- rst asserted mid-RUN -> all outputs 0 immediately (asynchronous), FSM IDLE; program store cleared.

Source files
------------

// File: rtl/march_sequencer_pkg.sv
// march_seq_defs: shared definitions for the march sequencer slice.
//
// Contents:
//   state_e     - sequencer FSM states (3-bit, IDLE = 0)
//   DEF_TMO     - default per-element watchdog limit in cycles
//   SCAN_*      - field positions of the BIST scan word, kept here so host
//                 software and the sequencer agree on one layout
package march_seq_defs;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STRT = 3'd2,
    ST_RUN  = 3'd3,
    ST_NEXT = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  localparam int DEF_TMO = 1024;

  // BIST scan word layout (16-bit scan_in)
  localparam int SCAN_OP_LSB    = 0;
  localparam int SCAN_OP_W      = 4;
  localparam int SCAN_DATA_LSB  = 4;
  localparam int SCAN_DATA_W    = 8;
  localparam int SCAN_DIR_BIT   = 12;
  localparam int SCAN_MODE_LSB  = 13;
  localparam int SCAN_MODE_W    = 3;

endpackage

// File: rtl/march_sequencer_watchdog.sv
// march_watchdog: per-element cycle counter for the march sequencer.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   clr_i     in   restart the count at zero
//   en_i      in   count this cycle
//   expire_o  out  count has reached TMO-1 while enabled
module march_watchdog
  import march_seq_defs::*;
#(
  parameter int TMO = DEF_TMO
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TMO - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturate at the limit so a stalled element keeps reporting expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/march_sequencer.sv
// march_sequencer: steps the memory BIST datapath through a stored march
// program, one element at a time, and collects pass/fail and watchdog status.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   prog_we/prog_addr/prog_wdata  program store write port (IDLE only)
//   prog_len                      elements to run (0..DEPTH), sampled at start
//   start, abort                  run request pulse, run termination
//   elem_done_in                  BIST element-complete pulse
//   cmp_valid_in, passfail_in     qualified compare result (1 = match)
//   tas_in                        BIST current address
//   scan_out, ts_out              scan word and test-start strobe to BIST
//   busy, done                    run in progress, run-finished pulse
//   fail, timeout                 sticky fail and watchdog flags
//   fail_idx, fail_addr           element index and address of first failure
//
// Build option: MARCH_SEQ_STOP_ON_FAIL_EN ends the run at the first recorded
// failure instead of running every element.
module march_sequencer
  import march_seq_defs::*;
#(
  parameter int SW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 8,
  parameter int IW    = 3,
  parameter int TMO   = DEF_TMO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_addr,
  input  logic [SW-1:0] prog_wdata,
  input  logic [IW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic          elem_done_in,
  input  logic          cmp_valid_in,
  input  logic          passfail_in,
  input  logic [AW-1:0] tas_in,
  output logic [SW-1:0] scan_out,
  output logic          ts_out,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          timeout,
  output logic [IW-1:0] fail_idx,
  output logic [AW-1:0] fail_addr
);

  state_e        state_q;
  logic [IW:0]   len_q;
  logic [IW-1:0] idx_q;
  logic [SW-1:0] prog_q [DEPTH];
  logic [SW-1:0] scan_q;
  logic          ts_q;
  logic          busy_q;
  logic          done_q;
  logic          fail_q;
  logic          tmo_q;
  logic [IW-1:0] fidx_q;
  logic [AW-1:0] faddr_q;

  logic wd_clr;
  logic wd_en;
  logic wd_expire;
  logic fail_evt;
  logic last_elem;

  assign fail_evt  = cmp_valid_in & ~passfail_in;
  assign last_elem = ({1'b0, idx_q} == (len_q - 1'b1));

  // The element's time budget starts with the strobe cycle, so the count is
  // zeroed during LOAD and runs through STRT and RUN.
  assign wd_clr = (state_q == ST_LOAD);
  assign wd_en  = (state_q == ST_STRT) || (state_q == ST_RUN);

  march_watchdog #(
    .TMO (TMO)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Program store: writable only while idle so a running program is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog_q[i] <= '0;
      end
    end else if ((state_q == ST_IDLE) && prog_we) begin
      prog_q[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer FSM. ts_out is raised on entry to STRT; done is raised while
  // leaving FIN so it appears together with busy falling. abort outranks
  // everything and leaves the result flags untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      scan_q  <= '0;
      ts_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fidx_q  <= '0;
      faddr_q <= '0;
    end else begin
      ts_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              len_q   <= prog_len;
              idx_q   <= '0;
              fail_q  <= 1'b0;
              tmo_q   <= 1'b0;
              fidx_q  <= '0;
              faddr_q <= '0;
              busy_q  <= 1'b1;
              state_q <= (prog_len == '0) ? ST_FIN : ST_LOAD;
            end
          end
          ST_LOAD: begin
            scan_q  <= prog_q[idx_q];
            ts_q    <= 1'b1;
            state_q <= ST_STRT;
          end
          ST_STRT: begin
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (fail_evt) begin
              fail_q <= 1'b1;
              if (!fail_q) begin
                fidx_q  <= idx_q;
                faddr_q <= tas_in;
              end
            end
`ifdef MARCH_SEQ_STOP_ON_FAIL_EN
            if (fail_evt && !fail_q) begin
              state_q <= ST_FIN;
            end else
`endif
            if (elem_done_in) begin
              state_q <= ST_NEXT;
            end else if (wd_expire) begin
              tmo_q   <= 1'b1;
              state_q <= ST_FIN;
            end
          end
          ST_NEXT: begin
            if (last_elem) begin
              state_q <= ST_FIN;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_LOAD;
            end
          end
          ST_FIN: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scan_out  = scan_q;
  assign ts_out    = ts_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign timeout   = tmo_q;
  assign fail_idx  = fidx_q;
  assign fail_addr = faddr_q;

endmodule

// File: tb/tb_march_sequencer.sv
// tb_march_sequencer: directed + randomized bench for march_sequencer.
// A reference model predicts, per run, the cycle of every ts_out pulse and the
// scan word shown with it, the done cycle, and the final result flags, from
// per-element timing rules (3 cycles overhead per element, TMO-cycle budget).
// Honours MARCH_SEQ_STOP_ON_FAIL_EN the same way the design does.
`timescale 1ns/1ps
module tb_march_sequencer;

  localparam int SW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int TMO   = 1024;
  localparam int LIMIT = 2 * TMO + 400;

  logic          clk;
  logic          rst;
  logic          prog_we;
  logic [IW-1:0] prog_addr;
  logic [SW-1:0] prog_wdata;
  logic [IW:0]   prog_len;
  logic          start;
  logic          abort;
  logic          elem_done_in;
  logic          cmp_valid_in;
  logic          passfail_in;
  logic [AW-1:0] tas_in;
  logic [SW-1:0] scan_out;
  logic          ts_out;
  logic          busy;
  logic          done;
  logic          fail;
  logic          timeout;
  logic [IW-1:0] fail_idx;
  logic [AW-1:0] fail_addr;

  march_sequencer #(
    .SW(SW), .AW(AW), .DEPTH(DEPTH), .IW(IW), .TMO(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .prog_len     (prog_len),
    .start        (start),
    .abort        (abort),
    .elem_done_in (elem_done_in),
    .cmp_valid_in (cmp_valid_in),
    .passfail_in  (passfail_in),
    .tas_in       (tas_in),
    .scan_out     (scan_out),
    .ts_out       (ts_out),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .timeout      (timeout),
    .fail_idx     (fail_idx),
    .fail_addr    (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: program contents and per-element BIST behaviour
  logic [SW-1:0] progM [DEPTH];
  int            elemDly [DEPTH];
  bit            elemFail [DEPTH];
  int            elemFailOff [DEPTH];
  logic [AW-1:0] elemFailAddr [DEPTH];

  // Expected and observed run results
  int            expTs[$];
  logic [SW-1:0] expScan[$];
  int            expDone;
  bit            expFail;
  bit            expTmo;
  int            expIdx;
  logic [AW-1:0] expAddr;
  int            obsTs[$];
  logic [SW-1:0] obsScan[$];
  int            obsDone[$];
  logic          abortBusy;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cycle 0 is the start cycle. An element strobed at cycle t runs from t+1;
  // a compare failure at cycle t+off is recorded; completion at t+dly leads to
  // the next strobe at t+dly+3 or, after the last element, done at t+dly+3.
  // A stalled element expires at t+TMO-1 and done follows at t+TMO+1.
  // abortCyc (>0) cuts off every event that happens at or after it.
  function automatic void buildExpect(input int len, input int abortCyc);
    int t;
    int f;
    int a;
    expTs.delete();
    expScan.delete();
    expDone = -1;
    expFail = 1'b0;
    expTmo  = 1'b0;
    expIdx  = 0;
    expAddr = '0;
    a = (abortCyc > 0) ? abortCyc : 32'h4000_0000;
    if (len == 0) begin
      if (2 <= a) expDone = 2;
      return;
    end
    t = 2;
    for (int e = 0; e < len; e++) begin
      if (t > a) return;
      expTs.push_back(t);
      expScan.push_back(progM[e]);
      if (elemDly[e] == 0) begin
        if (t + TMO - 1 < a) expTmo = 1'b1;
        if (t + TMO + 1 <= a) expDone = t + TMO + 1;
        return;
      end
      if (elemFail[e]) begin
        f = t + elemFailOff[e];
        if (f < a && !expFail) begin
          expFail = 1'b1;
          expIdx  = e;
          expAddr = elemFailAddr[e];
`ifdef MARCH_SEQ_STOP_ON_FAIL_EN
          if (f + 2 <= a) expDone = f + 2;
          return;
`endif
        end
      end
      if (e == len - 1) begin
        if (t + elemDly[e] + 3 <= a) expDone = t + elemDly[e] + 3;
        return;
      end
      t += elemDly[e] + 3;
    end
  endfunction

  task automatic writeProg(input int addr, input logic [SW-1:0] data);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = IW'(addr);
    prog_wdata = data;
    @(negedge clk);
    prog_we = 1'b0;
    progM[addr] = data;
  endtask

  // Plays the BIST side of one run cycle by cycle. While busy it also throws
  // ignored traffic at the sequencer: program writes, extra start pulses, and
  // a failing compare plus elem_done in every strobe cycle.
  task automatic applyStimulus(input int len, input int abortCyc);
    int curDone;
    int curFail;
    int e;
    int stopAt;
    obsTs.delete();
    obsScan.delete();
    obsDone.delete();
    abortBusy = 1'bx;
    curDone = -1;
    curFail = -1;
    e = -1;
    stopAt = -1;
    @(negedge clk);
    start    = 1'b1;
    prog_len = (IW+1)'(len);
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      start        = 1'b0;
      abort        = 1'b0;
      elem_done_in = 1'b0;
      cmp_valid_in = 1'b0;
      passfail_in  = 1'b1;
      tas_in       = AW'($urandom);
      prog_we      = 1'b0;
      if (busy === 1'b1) begin
        prog_we    = 1'($urandom_range(0, 1));
        prog_addr  = IW'($urandom);
        prog_wdata = SW'($urandom);
        prog_len   = (IW+1)'($urandom_range(0, DEPTH));
        start      = ($urandom_range(0, 7) == 0);
      end
      if (ts_out === 1'b1) begin
        obsTs.push_back(k);
        obsScan.push_back(scan_out);
        e++;
        if (e < DEPTH) begin
          curDone = (elemDly[e] == 0) ? -1 : k + elemDly[e];
          curFail = elemFail[e] ? k + elemFailOff[e] : -1;
        end
        elem_done_in = 1'b1;
        cmp_valid_in = 1'b1;
        passfail_in  = 1'b0;
      end
      if (k == curDone) elem_done_in = 1'b1;
      if (k == curFail && e >= 0 && e < DEPTH) begin
        cmp_valid_in = 1'b1;
        passfail_in  = 1'b0;
        tas_in       = elemFailAddr[e];
      end else if (ts_out !== 1'b1 && $urandom_range(0, 3) == 0) begin
        cmp_valid_in = 1'b1;
      end
      if (done === 1'b1) obsDone.push_back(k);
      if (k == abortCyc) abort = 1'b1;
      if (abortCyc > 0 && k == abortCyc + 1) abortBusy = busy;
      if (stopAt < 0 && done === 1'b1) stopAt = k + 4;
      if (stopAt < 0 && abortCyc > 0 && k == abortCyc + 1) stopAt = k + 6;
      if (k == stopAt) break;
    end
    start        = 1'b0;
    abort        = 1'b0;
    elem_done_in = 1'b0;
    cmp_valid_in = 1'b0;
    passfail_in  = 1'b1;
    prog_we      = 1'b0;
    prog_len     = '0;
  endtask

  task automatic runAndCheck(input string tag, input int len, input int abortCyc);
    buildExpect(len, abortCyc);
    applyStimulus(len, abortCyc);
    checkOutput($sformatf("%s.tsCount", tag), obsTs.size(), expTs.size());
    for (int i = 0; i < expTs.size() && i < obsTs.size(); i++) begin
      checkOutput($sformatf("%s.tsCycle%0d", tag, i), obsTs[i], expTs[i]);
      checkOutput($sformatf("%s.scan%0d", tag, i), 32'(obsScan[i]), 32'(expScan[i]));
    end
    checkOutput($sformatf("%s.doneCount", tag), obsDone.size(), (expDone < 0) ? 0 : 1);
    if (expDone >= 0 && obsDone.size() > 0)
      checkOutput($sformatf("%s.doneCycle", tag), obsDone[0], expDone);
    checkOutput($sformatf("%s.fail", tag), 32'(fail), 32'(expFail));
    checkOutput($sformatf("%s.timeout", tag), 32'(timeout), 32'(expTmo));
    checkOutput($sformatf("%s.failIdx", tag), 32'(fail_idx), expIdx);
    checkOutput($sformatf("%s.failAddr", tag), 32'(fail_addr), 32'(expAddr));
    checkOutput($sformatf("%s.busyEnd", tag), 32'(busy), 0);
    if (abortCyc > 0)
      checkOutput($sformatf("%s.busyAfterAbort", tag), 32'(abortBusy), 0);
  endtask

  task automatic clearElems(input int dly);
    for (int i = 0; i < DEPTH; i++) begin
      elemDly[i]      = dly;
      elemFail[i]     = 1'b0;
      elemFailOff[i]  = 1;
      elemFailAddr[i] = '0;
    end
  endtask

  task automatic randElems();
    for (int i = 0; i < DEPTH; i++) begin
      elemDly[i]      = $urandom_range(1, 12);
      elemFail[i]     = ($urandom_range(0, 2) == 0);
      elemFailOff[i]  = $urandom_range(1, elemDly[i]);
      elemFailAddr[i] = AW'($urandom);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s.scan", tag), 32'(scan_out), 0);
    checkOutput($sformatf("%s.ts", tag), 32'(ts_out), 0);
    checkOutput($sformatf("%s.busy", tag), 32'(busy), 0);
    checkOutput($sformatf("%s.done", tag), 32'(done), 0);
    checkOutput($sformatf("%s.fail", tag), 32'(fail), 0);
    checkOutput($sformatf("%s.timeout", tag), 32'(timeout), 0);
    checkOutput($sformatf("%s.failIdx", tag), 32'(fail_idx), 0);
    checkOutput($sformatf("%s.failAddr", tag), 32'(fail_addr), 0);
  endtask

  initial begin
    rst          = 1'b1;
    prog_we      = 1'b0;
    prog_addr    = '0;
    prog_wdata   = '0;
    prog_len     = '0;
    start        = 1'b0;
    abort        = 1'b0;
    elem_done_in = 1'b0;
    cmp_valid_in = 1'b0;
    passfail_in  = 1'b1;
    tas_in       = '0;
    for (int i = 0; i < DEPTH; i++) progM[i] = '0;
    clearElems(10);

    // Reset state
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Three-element program, all elements pass
    writeProg(0, 16'h1111);
    writeProg(1, 16'h2222);
    writeProg(2, 16'h3333);
    runAndCheck("pass3", 3, 0);

    // Failures in elements 1 and 2: only the first is captured
    clearElems(10);
    elemFail[1] = 1'b1; elemFailOff[1] = 3; elemFailAddr[1] = 8'h5A;
    elemFail[2] = 1'b1; elemFailOff[2] = 4; elemFailAddr[2] = 8'hC3;
    runAndCheck("fail3", 3, 0);

    // Element 0 never completes: watchdog ends the run
    clearElems(10);
    elemDly[0] = 0;
    runAndCheck("timeout", 2, 0);

    // Abort 4 cycles into element 0's RUN, after a recorded failure
    clearElems(20);
    elemFail[0] = 1'b1; elemFailOff[0] = 2; elemFailAddr[0] = 8'h3C;
    runAndCheck("abort", 3, 7);

    // Clean run after abort; entries 0..2 must survive the busy-time writes
    clearElems(0);
    for (int i = 0; i < DEPTH; i++) elemDly[i] = $urandom_range(1, 12);
    runAndCheck("afterAbort", 3, 0);

    // Empty program
    runAndCheck("len0", 0, 0);

    // Randomized programs and element behaviour
    for (int i = 0; i < DEPTH; i++) writeProg(i, SW'($urandom));
    for (int r = 0; r < 4; r++) begin
      randElems();
      runAndCheck($sformatf("rand%0d", r), (r == 0) ? DEPTH : $urandom_range(1, DEPTH), 0);
    end

    // Asynchronous reset in the middle of RUN
    clearElems(0);
    @(negedge clk);
    prog_len = 4'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    cmp_valid_in = 1'b1;
    passfail_in  = 1'b0;
    tas_in       = 8'hA7;
    @(negedge clk);
    cmp_valid_in = 1'b0;
    passfail_in  = 1'b1;
    checkOutput("preReset.busy", 32'(busy), 1);
    checkOutput("preReset.fail", 32'(fail), 1);
    checkOutput("preReset.failAddr", 32'(fail_addr), 32'h0A7);
    #2 rst = 1'b1;
    #1 checkAllZero("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) progM[i] = '0;

    // Full-depth run over the cleared program store
    clearElems(0);
    for (int i = 0; i < DEPTH; i++) elemDly[i] = $urandom_range(1, 8);
    runAndCheck("postReset", DEPTH, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
